// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing with memory
// wait states, bus timeout and illegal-opcode detection. Define CU_JUMP_EN to enable the J opcode.
module multicycle_control_unit #(
  parameter int ALUOP_W  = 3,
  parameter int WAIT_MAX = 16,
  parameter int STATE_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_source,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal_op,
  output logic               bus_error,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11
`ifdef CU_JUMP_EN
    , S_JUMP   = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
`ifdef CU_JUMP_EN
  localparam logic [5:0] OP_J    = 6'b000010;
`endif

  localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       aop;
  logic             timeout;

  assign timeout = (WAIT_MAX > 0) && (cnt == CNT_W'(WAIT_MAX - 1)) && !mem_ready;
  assign alu_op  = ALUOP_W'(aop);
  assign state_o = STATE_W'(state);

  // Only wait states ever self-loop, so a state change is the "entry" that clears the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (!mem_ready)    cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    aop           = 3'b000;
    illegal_op    = 1'b0;
    bus_error     = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end else if (timeout) begin
          bus_error = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_R:                               state_nxt = S_EXEC_R;
          OP_LW, OP_SW:                       state_nxt = S_MEM_ADDR;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  state_nxt = S_EXEC_I;
          OP_BEQ:                             state_nxt = S_BRANCH;
`ifdef CU_JUMP_EN
          OP_J:                               state_nxt = S_JUMP;
`endif
          default: begin
            illegal_op = 1'b1;
            state_nxt  = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)    state_nxt = S_MEM_WB;
        else if (timeout) begin
          bus_error = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready)    state_nxt = S_FETCH;
        else if (timeout) begin
          bus_error = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        aop       = 3'b010;
        state_nxt = S_R_WB;
      end
      S_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_nxt = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OP_SLTI: aop = 3'b001;
          OP_ANDI: aop = 3'b011;
          OP_ORI:  aop = 3'b100;
          default: aop = 3'b000;
        endcase
        state_nxt = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        aop           = 3'b101;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_nxt     = S_FETCH;
      end
`ifdef CU_JUMP_EN
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_nxt = S_FETCH;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
